// File: rtl/idex_hazard_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register slice.
//   DATA_W  : operand / immediate width
//   REG_W   : register-ID width (R0 is hard-wired zero)
//   ALUOP_W : ALU opcode width
//   CNT_W   : default stall-counter width
// Also holds the control values that make up a NOP bubble and the R0 ID.
package idex_hazard_reg_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_W   = 4;
  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 16;

  // R0 reads as zero and is never a real producer.
  localparam logic [REG_W-1:0] R0 = '0;

  // Bubble control: no write-back, no memory access, ALU op 0.
  localparam logic               BUBBLE_REGWRITE = 1'b0;
  localparam logic               BUBBLE_MEMREAD  = 1'b0;
  localparam logic               BUBBLE_MEMWRITE = 1'b0;
  localparam logic [ALUOP_W-1:0] BUBBLE_ALUOP    = '0;

endpackage

// File: rtl/idex_hazard_reg_load_use.sv
// load_use_detect: purely combinational load-use hazard compare.
//   memReadEx  : instruction in EX is a load
//   dstRegEx   : destination of the instruction in EX
//   srcReg1Id  : source 1 of the instruction in ID
//   srcReg2Id  : source 2 of the instruction in ID (store data for stores)
//   memWriteId : instruction in ID is a store
//   loadUse    : ID must wait one cycle for the load result
module load_use_detect
  import idex_hazard_reg_pkg::*;
#(
  parameter int RW = REG_W
) (
  input  logic          memReadEx,
  input  logic [RW-1:0] dstRegEx,
  input  logic [RW-1:0] srcReg1Id,
  input  logic [RW-1:0] srcReg2Id,
  input  logic          memWriteId,
  output logic          loadUse
);

  logic dstIsReal;
  logic hitSrc1;
  logic hitSrc2;

  assign dstIsReal = (dstRegEx != RW'(R0));
  assign hitSrc1   = (dstRegEx == srcReg1Id);
  // Store data coming from a load is handled by MEM-to-MEM forwarding,
  // so only a non-store source 2 match needs a stall.
  assign hitSrc2   = (dstRegEx == srcReg2Id) & ~memWriteId;
  assign loadUse   = memReadEx & dstIsReal & (hitSrc1 | hitSrc2);

endmodule

// File: rtl/idex_hazard_reg.sv
// idex_hazard_reg: ID/EX pipeline register with load-use bubble insertion.
//   clk, rst        : clock, synchronous active-high reset
//   hold            : global freeze, every register keeps its value
//   flush           : branch taken, the ID instruction becomes a bubble
//   *_ID            : decoded control, register IDs and operands from ID
//   *_EX            : the same fields registered for EX / forwarding unit
//   stall_PC/IFID   : combinational freeze request for PC and IF/ID
//   stall_count     : saturating count of load-use bubbles since reset
// Update priority per edge: rst, hold, flush, load-use bubble, capture.
module idex_hazard_reg
  import idex_hazard_reg_pkg::*;
#(
  parameter int DATA_W  = idex_hazard_reg_pkg::DATA_W,
  parameter int REG_W   = idex_hazard_reg_pkg::REG_W,
  parameter int ALUOP_W = idex_hazard_reg_pkg::ALUOP_W,
  parameter int CNT_W   = idex_hazard_reg_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               flush,
  input  logic               RegWrite_ID,
  input  logic               MemRead_ID,
  input  logic               MemWrite_ID,
  input  logic [ALUOP_W-1:0] ALUOp_ID,
  input  logic [REG_W-1:0]   SrcReg1_ID,
  input  logic [REG_W-1:0]   SrcReg2_ID,
  input  logic [REG_W-1:0]   DstReg1_ID,
  input  logic [DATA_W-1:0]  RegData1_ID,
  input  logic [DATA_W-1:0]  RegData2_ID,
  input  logic [DATA_W-1:0]  Imm_ID,
  output logic               RegWrite_EX,
  output logic               MemRead_EX,
  output logic               MemWrite_EX,
  output logic [ALUOP_W-1:0] ALUOp_EX,
  output logic [REG_W-1:0]   SrcReg1_EX,
  output logic [REG_W-1:0]   SrcReg2_EX,
  output logic [REG_W-1:0]   DstReg1_EX,
  output logic [DATA_W-1:0]  RegData1_EX,
  output logic [DATA_W-1:0]  RegData2_EX,
  output logic [DATA_W-1:0]  Imm_EX,
  output logic               stall_PC,
  output logic               stall_IFID,
  output logic [CNT_W-1:0]   stall_count
);

  logic loadUse;
  logic insertBubble;

  load_use_detect #(
    .RW(REG_W)
  ) uLoadUse (
    .memReadEx (MemRead_EX),
    .dstRegEx  (DstReg1_EX),
    .srcReg1Id (SrcReg1_ID),
    .srcReg2Id (SrcReg2_ID),
    .memWriteId(MemWrite_ID),
    .loadUse   (loadUse)
  );

  // A flushed ID instruction is discarded, so freezing the front end for it
  // would only waste a cycle. hold does not gate the request.
  assign stall_PC     = loadUse & ~flush;
  assign stall_IFID   = loadUse & ~flush;
  assign insertBubble = flush | loadUse;

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite_EX <= BUBBLE_REGWRITE;
      MemRead_EX  <= BUBBLE_MEMREAD;
      MemWrite_EX <= BUBBLE_MEMWRITE;
      ALUOp_EX    <= ALUOP_W'(BUBBLE_ALUOP);
      SrcReg1_EX  <= REG_W'(R0);
      SrcReg2_EX  <= REG_W'(R0);
      DstReg1_EX  <= REG_W'(R0);
      RegData1_EX <= '0;
      RegData2_EX <= '0;
      Imm_EX      <= '0;
      stall_count <= '0;
    end else if (hold) begin
      // Everything retains its value.
    end else if (insertBubble) begin
      // RegWrite=0 and DstReg1=R0 keep the forwarding unit from matching.
      RegWrite_EX <= BUBBLE_REGWRITE;
      MemRead_EX  <= BUBBLE_MEMREAD;
      MemWrite_EX <= BUBBLE_MEMWRITE;
      ALUOp_EX    <= ALUOP_W'(BUBBLE_ALUOP);
      SrcReg1_EX  <= REG_W'(R0);
      SrcReg2_EX  <= REG_W'(R0);
      DstReg1_EX  <= REG_W'(R0);
      RegData1_EX <= '0;
      RegData2_EX <= '0;
      Imm_EX      <= '0;
      // Only load-use bubbles are counted; flush takes priority.
      if (!flush && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end else begin
      RegWrite_EX <= RegWrite_ID;
      MemRead_EX  <= MemRead_ID;
      MemWrite_EX <= MemWrite_ID;
      ALUOp_EX    <= ALUOp_ID;
      SrcReg1_EX  <= SrcReg1_ID;
      SrcReg2_EX  <= SrcReg2_ID;
      DstReg1_EX  <= DstReg1_ID;
      RegData1_EX <= RegData1_ID;
      RegData2_EX <= RegData2_ID;
      Imm_EX      <= Imm_ID;
    end
  end

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Directed bench for idex_hazard_reg, built with a 2-bit stall counter so
// saturation is reachable in a handful of stalls.
module tb_idex_hazard_reg;

  localparam int CW = 2;
  localparam int VW = 67;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        flush;
  logic        RegWrite_ID, MemRead_ID, MemWrite_ID;
  logic [3:0]  ALUOp_ID, SrcReg1_ID, SrcReg2_ID, DstReg1_ID;
  logic [15:0] RegData1_ID, RegData2_ID, Imm_ID;
  logic        RegWrite_EX, MemRead_EX, MemWrite_EX;
  logic [3:0]  ALUOp_EX, SrcReg1_EX, SrcReg2_EX, DstReg1_EX;
  logic [15:0] RegData1_EX, RegData2_EX, Imm_EX;
  logic        stall_PC, stall_IFID;
  logic [CW-1:0] stall_count;

  int checks;
  int failures;
  logic [VW-1:0] exp_q[$];

  idex_hazard_reg #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID),
    .MemWrite_ID(MemWrite_ID), .ALUOp_ID(ALUOp_ID),
    .SrcReg1_ID(SrcReg1_ID), .SrcReg2_ID(SrcReg2_ID),
    .DstReg1_ID(DstReg1_ID), .RegData1_ID(RegData1_ID),
    .RegData2_ID(RegData2_ID), .Imm_ID(Imm_ID),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
    .MemWrite_EX(MemWrite_EX), .ALUOp_EX(ALUOp_EX),
    .SrcReg1_EX(SrcReg1_EX), .SrcReg2_EX(SrcReg2_EX),
    .DstReg1_EX(DstReg1_EX), .RegData1_EX(RegData1_EX),
    .RegData2_EX(RegData2_EX), .Imm_EX(Imm_EX),
    .stall_PC(stall_PC), .stall_IFID(stall_IFID),
    .stall_count(stall_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed ID bundle: rw, mr, mw, aluop, s1, s2, d, rd1, rd2, imm.
  function automatic logic [VW-1:0] mk(input logic rw, input logic mr,
      input logic mw, input logic [3:0] op, input logic [3:0] s1,
      input logic [3:0] s2, input logic [3:0] d, input logic [15:0] r1,
      input logic [15:0] r2, input logic [15:0] im);
    return {rw, mr, mw, op, s1, s2, d, r1, r2, im};
  endfunction

  function automatic logic [VW-1:0] ex_vec();
    return {RegWrite_EX, MemRead_EX, MemWrite_EX, ALUOp_EX, SrcReg1_EX,
            SrcReg2_EX, DstReg1_EX, RegData1_EX, RegData2_EX, Imm_EX};
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] obs,
                       input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_id(input logic [VW-1:0] v);
    {RegWrite_ID, MemRead_ID, MemWrite_ID, ALUOp_ID, SrcReg1_ID, SrcReg2_ID,
     DstReg1_ID, RegData1_ID, RegData2_ID, Imm_ID} = v;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Clock one edge and compare the EX bundle with the queued expectation.
  task automatic expect_ex(input string tag, input logic [VW-1:0] e);
    exp_q.push_back(e);
    step();
    check(tag, ex_vec(), exp_q.pop_front());
  endtask

  logic [VW-1:0] lw3, add5, sw3, lw0, add6, addf, lw7, add8, lw4d, add9;

  initial begin
    checks = 0;
    failures = 0;
    lw3  = mk(1, 1, 0, 4'h2, 4'd1, 4'd0, 4'd3, 16'h0100, 16'h0000, 16'h0004);
    add5 = mk(1, 0, 0, 4'h1, 4'd3, 4'd4, 4'd5, 16'h1111, 16'h2222, 16'h0000);
    sw3  = mk(0, 0, 1, 4'h2, 4'd2, 4'd3, 4'd0, 16'h0200, 16'h3333, 16'h0008);
    lw0  = mk(1, 1, 0, 4'h2, 4'd1, 4'd0, 4'd0, 16'h0100, 16'h0000, 16'h0010);
    add6 = mk(1, 0, 0, 4'h1, 4'd0, 4'd0, 4'd6, 16'h0000, 16'h0000, 16'h0000);
    addf = mk(1, 0, 0, 4'h3, 4'd3, 4'd1, 4'd9, 16'h5555, 16'h6666, 16'h0000);
    lw7  = mk(1, 1, 0, 4'h2, 4'd2, 4'd0, 4'd7, 16'h0300, 16'h0000, 16'h0002);
    add8 = mk(1, 0, 0, 4'h1, 4'd7, 4'd2, 4'd8, 16'h7777, 16'h8888, 16'h0000);
    lw4d = mk(1, 1, 0, 4'h2, 4'd3, 4'd0, 4'd4, 16'h0000, 16'h0000, 16'h000C);
    add9 = mk(1, 0, 0, 4'h1, 4'd4, 4'd4, 4'd10, 16'hAAAA, 16'hBBBB, 16'h0000);

    // Reset with non-zero ID inputs and hold/flush high: rst wins.
    rst = 1'b1; hold = 1'b1; flush = 1'b1;
    drive_id(lw3);
    step();
    step();
    check("reset_ex", ex_vec(), '0);
    check("reset_count", VW'(stall_count), VW'(0));
    check("reset_stall", VW'(stall_PC), VW'(0));
    rst = 1'b0; hold = 1'b0; flush = 1'b0;

    // Load-use: LW R3 then ADD R5,R3,R4.
    drive_id(lw3);
    expect_ex("lw3_capture", lw3);
    drive_id(add5);
    check("lu_stall_pc", VW'(stall_PC), VW'(1));
    check("lu_stall_ifid", VW'(stall_IFID), VW'(1));
    expect_ex("lu_bubble", '0);
    check("lu_count", VW'(stall_count), VW'(1));
    check("lu_no_second_stall", VW'(stall_PC), VW'(0));
    expect_ex("lu_add_enters", add5);
    check("lu_src1", VW'(SrcReg1_EX), VW'(3));

    // Store data from a load: no stall.
    drive_id(lw3);
    expect_ex("lw3_again", lw3);
    drive_id(sw3);
    check("sw_no_stall", VW'(stall_PC), VW'(0));
    expect_ex("sw_capture", sw3);
    check("sw_count", VW'(stall_count), VW'(1));

    // Load to R0 never stalls.
    drive_id(lw0);
    expect_ex("lw0_capture", lw0);
    drive_id(add6);
    check("r0_no_stall", VW'(stall_IFID), VW'(0));
    expect_ex("r0_add_capture", add6);

    // Flush beats a live hazard: no stall, bubble, count unchanged.
    drive_id(lw3);
    expect_ex("lw3_flush", lw3);
    flush = 1'b1;
    drive_id(addf);
    check("flush_stall_pc", VW'(stall_PC), VW'(0));
    expect_ex("flush_bubble", '0);
    check("flush_count", VW'(stall_count), VW'(1));
    flush = 1'b0;

    // Hold for 3 cycles with a live hazard and toggling ID data.
    drive_id(lw7);
    expect_ex("lw7_capture", lw7);
    hold = 1'b1;
    drive_id(add8);
    check("hold_stall_pc", VW'(stall_PC), VW'(1));
    for (int i = 0; i < 3; i++) begin
      add8[47:32] = 16'h7770 + 16'(i);
      drive_id(add8);
      expect_ex($sformatf("hold_ex_%0d", i), lw7);
      check($sformatf("hold_count_%0d", i), VW'(stall_count), VW'(1));
    end
    hold = 1'b0;
    expect_ex("hold_release_bubble", '0);
    check("hold_release_count", VW'(stall_count), VW'(2));
    expect_ex("hold_add_enters", add8);

    // Back-to-back loads: dependent LW R4 then dependent ADD; counter
    // reaches 3 and then saturates.
    drive_id(lw3);
    expect_ex("b2b_lw3", lw3);
    drive_id(lw4d);
    check("b2b_stall1", VW'(stall_PC), VW'(1));
    expect_ex("b2b_bubble1", '0);
    check("b2b_count3", VW'(stall_count), VW'(3));
    check("b2b_single_bubble", VW'(stall_PC), VW'(0));
    expect_ex("b2b_lw4_enters", lw4d);
    drive_id(add9);
    check("b2b_stall2", VW'(stall_PC), VW'(1));
    expect_ex("b2b_bubble2", '0);
    check("sat_count_a", VW'(stall_count), VW'(3));
    expect_ex("b2b_add_enters", add9);

    // One more dependent pair: still 3, no wrap.
    drive_id(lw3);
    expect_ex("sat_lw3", lw3);
    drive_id(add5);
    expect_ex("sat_bubble", '0);
    check("sat_count_b", VW'(stall_count), VW'(3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idex_hazard_reg.md
Name: idex_hazard_reg

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage, 16-bit pipeline.
- Captures decoded operands, register IDs and control from ID and presents them to EX.
- Its register IDs, RegWrite and MemRead outputs feed the forwarding unit and the EX operand muxes.
- Inserts bubbles on load-use hazards, kills instructions on branch flush, freezes on global hold, and keeps a saturating stall counter.

Parameters:
DATA_W, 16, operand/immediate width
REG_W, 4, register-ID width (R0 hard-wired zero)
ALUOP_W, 4, ALU opcode width
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
hold  input  1  global freeze (memory not ready); register retains contents
flush  input  1  branch taken in ID; instruction in ID must not enter EX
RegWrite_ID  input  1  ID instruction writes DstReg1
MemRead_ID  input  1  ID instruction is a load
MemWrite_ID  input  1  ID instruction is a store
ALUOp_ID  input  ALUOP_W  ALU operation
SrcReg1_ID  input  REG_W  source register 1
SrcReg2_ID  input  REG_W  source register 2 (store data for stores)
DstReg1_ID  input  REG_W  destination register
RegData1_ID  input  DATA_W  register-file read 1
RegData2_ID  input  DATA_W  register-file read 2
Imm_ID  input  DATA_W  sign/zero-extended immediate
RegWrite_EX  output  1  registered control
MemRead_EX  output  1  registered control
MemWrite_EX  output  1  registered control
ALUOp_EX  output  ALUOP_W  registered control
SrcReg1_EX  output  REG_W  to forwarding unit
SrcReg2_EX  output  REG_W  to forwarding unit
DstReg1_EX  output  REG_W  to forwarding unit (LLB/LHB) and EX/MEM
RegData1_EX  output  DATA_W  registered operand
RegData2_EX  output  DATA_W  registered operand
Imm_EX  output  DATA_W  registered immediate
stall_PC  output  1  freeze PC (combinational)
stall_IFID  output  1  freeze IF/ID register (combinational)
stall_count  output  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: all registered outputs are 0 (a NOP bubble) and stall_count is 0. rst is sampled only at clk edge and overrides hold/flush.
- Load-use detect (combinational):
  - load_use = MemRead_EX & (DstReg1_EX != 0) & ((DstReg1_EX == SrcReg1_ID) | ((DstReg1_EX == SrcReg2_ID) & ~MemWrite_ID)).
  - Store-data dependence is excluded because MEM-to-MEM forwarding covers it.
- stall_PC = stall_IFID = load_use & ~flush.
  - Independent of hold.
  - Flush wins because the ID instruction is discarded anyway.
- Per-edge update, priority order:
  1. rst: clear everything.
  2. hold: all registers and stall_count retain their values.
  3. flush: load a bubble. RegWrite/MemRead/MemWrite/ALUOp and all register IDs = 0; data fields = 0. stall_count unchanged.
  4. load_use: load a bubble (same as flush) and increment stall_count, saturating at 2^CNT_W-1 with no wrap.
  5. Otherwise: capture all _ID inputs.
- Latency: ID inputs appear on _EX outputs 1 cycle later.
  - A load-use stall costs exactly 1 bubble: the next cycle MemRead_EX = 0, so load_use drops and the held instruction enters.
- A bubble must have RegWrite_EX = 0 and DstReg1_EX = 0 so the forwarding unit never matches it.
- Instructions with DstReg1 = R0 never trigger a stall.
- Back-to-back loads: each dependent consumer stalls independently; there are no double bubbles for a single dependence.

Decomposition:
- Shared package holds:
  - DATA_W, REG_W, ALUOP_W.
  - NOP/bubble control constants.
  - The R0 constant.
- One natural sub-module: `load_use_detect` (purely combinational hazard compare), reused by the top-level hazard logic.
- Register and counter logic stays in the top module.

Test Plan:
- Reset: assert rst 2 cycles with nonzero ID inputs -> all _EX outputs 0, stall_count 0, stall_PC 0.
- Load-use:
  - Stimulus: LW R3 in EX, ID has ADD R5,R3,R4.
  - Required: stall_PC = stall_IFID = 1 that cycle; next edge RegWrite_EX = 0, DstReg1_EX = 0, stall_count = 1.
  - Following edge: SrcReg1_EX = 3 with no further stall.
- Store exemption and R0:
  - LW R3 then SW with SrcReg2_ID = 3 -> no stall, SW captured next cycle.
  - LW R0 then ADD using R0 -> no stall.
- Flush vs hazard: load_use condition true and flush = 1 -> stall_PC = 0; EX gets a bubble; stall_count unchanged.
- Hold: hold = 1 for 3 cycles while ID inputs toggle and load_use = 1 -> _EX outputs and stall_count frozen. After release, a single bubble and count +1.
- Saturation: preload by forcing 65535 dependent load pairs (or reduce CNT_W to 2 and force 4 stalls) -> count stops at 3, no wrap to 0.
